// File: rtl/data_memory.sv
// -----------------------------------------------------------------------------
// data_memory
// Word-organised data memory with a single outstanding load/store request and
// a fixed, parameterised response latency.
//
// Parameters
//   WD_SIZE   : data and address width in bits (default 32)
//   MEM_WORDS : number of WD_SIZE-bit words, power of two, >= 2 (default 128)
//   LATENCY   : cycles from request acceptance to response, 1..15 (default 1)
//
// Ports
//   clk      in   sole clock, rising edge
//   reset    in   synchronous active-high reset
//   op_en    in   request valid
//   rd_wr    in   1 = store, 0 = load
//   addr     in   byte address; word index is addr[log2(MEM_WORDS)+1:2]
//   wr_data  in   store data
//   ready    out  a request can be accepted this cycle
//   rd_data  out  load data, meaningful while rd_valid=1, holds otherwise
//   rd_valid out  one-cycle load response pulse
//   wr_done  out  one-cycle store-committed pulse
//   misalign out  qualifies the current response as misaligned
//
// Build option
//   DMEM_MISALIGN_TRAP_EN : when defined, requests with addr[1:0] != 0 do not
//   touch the array and respond with misalign=1 (loads return 0). When
//   undefined, addr[1:0] is ignored and misalign is tied to 0.
// -----------------------------------------------------------------------------
module data_memory #(
    parameter int WD_SIZE   = 32,
    parameter int MEM_WORDS = 128,
    parameter int LATENCY   = 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               op_en,
    input  logic               rd_wr,
    input  logic [WD_SIZE-1:0] addr,
    input  logic [WD_SIZE-1:0] wr_data,
    output logic               ready,
    output logic [WD_SIZE-1:0] rd_data,
    output logic               rd_valid,
    output logic               wr_done,
    output logic               misalign
);

    localparam int IDX_W = $clog2(MEM_WORDS);
    // WAIT is entered with LATENCY-2 so that the edge seeing 0 enters RESP.
    localparam logic [3:0] CNT_LOAD = (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t               state_reg, state_next;
    logic [3:0]           cnt_reg, cnt_next;
    logic                 ready_int;
    logic                 accept;
    logic                 commit;
    logic                 mis_in;
    logic [IDX_W-1:0]     idx_in;

    // The request as it applies on the edge entering RESP.
    logic                 op_store;
    logic                 op_mis;
    logic [IDX_W-1:0]     op_idx;
    logic [WD_SIZE-1:0]   op_data;

    logic                 resp_store_reg;
    logic                 resp_mis_reg;
    logic [WD_SIZE-1:0]   rd_data_reg;

    logic [WD_SIZE-1:0]   mem [MEM_WORDS];

    logic                 unused_bits;

    assign idx_in    = addr[IDX_W+1:2];
    assign ready_int = (state_reg != WAIT);
    assign accept    = op_en && ready_int && !reset;

`ifdef DMEM_MISALIGN_TRAP_EN
    assign mis_in = (addr[1:0] != 2'b00);
`else
    assign mis_in = 1'b0;
`endif

    // Upper address bits only alias the array; low bits matter only with the trap.
    assign unused_bits = ^{addr[WD_SIZE-1:IDX_W+2], addr[1:0], resp_mis_reg};

    // With LATENCY=1 the request commits on its own acceptance edge, so the
    // live inputs are used and no capture registers exist.
    generate
        if (LATENCY == 1) begin : g_direct
            assign op_store = rd_wr;
            assign op_mis   = mis_in;
            assign op_idx   = idx_in;
            assign op_data  = wr_data;
        end else begin : g_captured
            logic               req_store_reg;
            logic               req_mis_reg;
            logic [IDX_W-1:0]   req_idx_reg;
            logic [WD_SIZE-1:0] req_data_reg;

            always_ff @(posedge clk) begin
                if (accept) begin
                    req_store_reg <= rd_wr;
                    req_mis_reg   <= mis_in;
                    req_idx_reg   <= idx_in;
                    req_data_reg  <= wr_data;
                end
            end

            assign op_store = req_store_reg;
            assign op_mis   = req_mis_reg;
            assign op_idx   = req_idx_reg;
            assign op_data  = req_data_reg;
        end
    endgenerate

    // Edge entering RESP: end of the WAIT count, or acceptance at LATENCY=1.
    assign commit = !reset &&
                    (((state_reg == WAIT) && (cnt_reg == 4'd0)) ||
                     (accept && (LATENCY == 1)));

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE;
            cnt_reg   <= 4'd0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            IDLE, RESP: begin
                if (accept) begin
                    if (LATENCY == 1) begin
                        state_next = RESP;
                    end else begin
                        state_next = WAIT;
                        cnt_next   = CNT_LOAD;
                    end
                end else begin
                    state_next = IDLE;
                end
            end
            WAIT: begin
                if (cnt_reg == 4'd0) begin
                    state_next = RESP;
                end else begin
                    cnt_next = cnt_reg - 4'd1;
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = 4'd0;
            end
        endcase
    end

    // Response registers; the array itself is never reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            resp_store_reg <= 1'b0;
            resp_mis_reg   <= 1'b0;
            rd_data_reg    <= '0;
        end else if (commit) begin
            resp_store_reg <= op_store;
            resp_mis_reg   <= op_mis;
            if (!op_store) begin
                rd_data_reg <= op_mis ? '0 : mem[op_idx];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (commit && op_store && !op_mis) begin
            mem[op_idx] <= op_data;
        end
    end

    // Output logic
    always_comb begin
        ready    = ready_int && !reset;
        rd_data  = reset ? '0 : rd_data_reg;
        rd_valid = (state_reg == RESP) && !resp_store_reg && !reset;
        wr_done  = (state_reg == RESP) &&  resp_store_reg && !reset;
`ifdef DMEM_MISALIGN_TRAP_EN
        misalign = (state_reg == RESP) && resp_mis_reg && !reset;
`else
        misalign = 1'b0;
`endif
    end

endmodule

// File: tb/tb_data_memory.sv
// -----------------------------------------------------------------------------
// tb_data_memory
// Directed bench for data_memory. Three instances run side by side with
// LATENCY = 1, 3 and 4; each is exercised in turn while the others sit idle.
// Inputs change 1 time unit after a rising edge and outputs are sampled there,
// so each sample shows the cycle that follows that edge.
// -----------------------------------------------------------------------------
module tb_data_memory;

    logic        clk = 1'b0;
    logic        rst [3];
    logic        en  [3];
    logic        wr  [3];
    logic [31:0] ad  [3];
    logic [31:0] wd  [3];
    logic        rdy [3];
    logic        rdv [3];
    logic        wrd [3];
    logic        mis [3];
    logic [31:0] rdd [3];

    int n_cmp = 0;
    int n_err = 0;

`ifdef DMEM_MISALIGN_TRAP_EN
    localparam logic [31:0] EXP_MIS_DATA = 32'h0000_0000;
    localparam logic [31:0] EXP_MIS_FLAG = 32'd1;
`else
    localparam logic [31:0] EXP_MIS_DATA = 32'hDEAD_BEEF;
    localparam logic [31:0] EXP_MIS_FLAG = 32'd0;
`endif

    always #5 clk = ~clk;

    data_memory #(.WD_SIZE(32), .MEM_WORDS(128), .LATENCY(1)) u_lat1 (
        .clk(clk), .reset(rst[0]), .op_en(en[0]), .rd_wr(wr[0]), .addr(ad[0]),
        .wr_data(wd[0]), .ready(rdy[0]), .rd_data(rdd[0]), .rd_valid(rdv[0]),
        .wr_done(wrd[0]), .misalign(mis[0]));

    data_memory #(.WD_SIZE(32), .MEM_WORDS(128), .LATENCY(3)) u_lat3 (
        .clk(clk), .reset(rst[1]), .op_en(en[1]), .rd_wr(wr[1]), .addr(ad[1]),
        .wr_data(wd[1]), .ready(rdy[1]), .rd_data(rdd[1]), .rd_valid(rdv[1]),
        .wr_done(wrd[1]), .misalign(mis[1]));

    data_memory #(.WD_SIZE(32), .MEM_WORDS(128), .LATENCY(4)) u_lat4 (
        .clk(clk), .reset(rst[2]), .op_en(en[2]), .rd_wr(wr[2]), .addr(ad[2]),
        .wr_data(wd[2]), .ready(rdy[2]), .rd_data(rdd[2]), .rd_valid(rdv[2]),
        .wr_done(wrd[2]), .misalign(mis[2]));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic req(input int d, input logic is_wr, input logic [31:0] a, input logic [31:0] w);
        en[d] = 1'b1;
        wr[d] = is_wr;
        ad[d] = a;
        wd[d] = w;
        $display("txn dut=%0d %s addr=0x%08h data=0x%08h", d, is_wr ? "store" : "load ", a, w);
    endtask

    task automatic idle(input int d);
        en[d] = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 3; i++) begin
            rst[i] = 1'b1; en[i] = 1'b0; wr[i] = 1'b0; ad[i] = '0; wd[i] = '0;
        end

        // Reset values while reset is held
        tick();
        check("rst_ready",    32'(rdy[0]), 32'd0);
        check("rst_rd_valid", 32'(rdv[0]), 32'd0);
        check("rst_wr_done",  32'(wrd[0]), 32'd0);
        check("rst_misalign", 32'(mis[0]), 32'd0);
        check("rst_rd_data",  rdd[0],      32'd0);
        tick();
        for (int i = 0; i < 3; i++) rst[i] = 1'b0;
        #1;
        check("ready_after_rst", 32'(rdy[0]), 32'd1);

        // ---------------- LATENCY=1 ----------------
        req(0, 1'b1, 32'h10, 32'hDEAD_BEEF);
        tick();
        check("l1_store_wr_done", 32'(wrd[0]), 32'd1);
        check("l1_store_rd_valid", 32'(rdv[0]), 32'd0);
        check("l1_store_ready", 32'(rdy[0]), 32'd1);
        req(0, 1'b0, 32'h10, 32'h0);
        tick();
        check("l1_load_rd_valid", 32'(rdv[0]), 32'd1);
        check("l1_load_wr_done",  32'(wrd[0]), 32'd0);
        check("l1_load_data",     rdd[0],      32'hDEAD_BEEF);
        check("l1_load_ready",    32'(rdy[0]), 32'd1);

        // Address wrap: 0x200 aliases word 0
        req(0, 1'b1, 32'h000, 32'h1);
        tick();
        check("wrap_store_wr_done", 32'(wrd[0]), 32'd1);
        req(0, 1'b0, 32'h200, 32'h0);
        tick();
        check("wrap_rd_valid", 32'(rdv[0]), 32'd1);
        check("wrap_data",     rdd[0],      32'h1);

        // Top word of the array
        req(0, 1'b1, 32'h1FC, 32'hA5A5_5A5A);
        tick();
        req(0, 1'b0, 32'h1FC, 32'h0);
        tick();
        check("top_word_data", rdd[0], 32'hA5A5_5A5A);

        // Misaligned load of 0x13
        req(0, 1'b0, 32'h13, 32'h0);
        tick();
        check("mis_rd_valid", 32'(rdv[0]), 32'd1);
        check("mis_flag",     32'(mis[0]), EXP_MIS_FLAG);
        check("mis_data",     rdd[0],      EXP_MIS_DATA);

        // Back to IDLE: pulses drop, rd_data holds
        idle(0);
        tick();
        check("idle_rd_valid", 32'(rdv[0]), 32'd0);
        check("idle_wr_done",  32'(wrd[0]), 32'd0);
        check("idle_hold",     rdd[0],      EXP_MIS_DATA);
        check("idle_ready",    32'(rdy[0]), 32'd1);

        // ---------------- LATENCY=3 ----------------
        req(1, 1'b1, 32'h10, 32'hCAFE_F00D);
        tick();                                   // E0: store accepted
        check("l3_e0_ready", 32'(rdy[1]), 32'd0);
        req(1, 1'b0, 32'h10, 32'h0);              // load held through WAIT
        tick();                                   // E1
        check("l3_e1_ready",   32'(rdy[1]), 32'd0);
        check("l3_e1_wr_done", 32'(wrd[1]), 32'd0);
        tick();                                   // E2: store commits
        check("l3_e2_wr_done",  32'(wrd[1]), 32'd1);
        check("l3_e2_rd_valid", 32'(rdv[1]), 32'd0);
        check("l3_e2_ready",    32'(rdy[1]), 32'd1);
        tick();                                   // E3: held load accepted
        idle(1);
        check("l3_e3_ready",    32'(rdy[1]), 32'd0);
        check("l3_e3_wr_done",  32'(wrd[1]), 32'd0);
        tick();                                   // E4
        check("l3_e4_rd_valid", 32'(rdv[1]), 32'd0);
        tick();                                   // E5: load response
        check("l3_e5_rd_valid", 32'(rdv[1]), 32'd1);
        check("l3_e5_data",     rdd[1],      32'hCAFE_F00D);
        tick();
        check("l3_e6_rd_valid", 32'(rdv[1]), 32'd0);
        check("l3_e6_ready",    32'(rdy[1]), 32'd1);

        // ---------------- LATENCY=4 ----------------
        req(2, 1'b1, 32'h20, 32'h1111_2222);
        tick();
        idle(2);
        tick();
        tick();
        tick();
        check("l4_init_wr_done", 32'(wrd[2]), 32'd1);
        tick();
        req(2, 1'b1, 32'h20, 32'h55);
        tick();                                   // accepted, now WAIT
        idle(2);
        tick();                                   // still WAIT
        rst[2] = 1'b1;
        tick();                                   // reset drops the pending store
        check("l4_rst_wr_done", 32'(wrd[2]), 32'd0);
        check("l4_rst_ready",   32'(rdy[2]), 32'd0);
        rst[2] = 1'b0;
        tick();
        check("l4_post_rst_wr_done", 32'(wrd[2]), 32'd0);
        check("l4_post_rst_ready",   32'(rdy[2]), 32'd1);
        req(2, 1'b0, 32'h20, 32'h0);
        tick();
        idle(2);
        tick();
        tick();
        check("l4_load_early", 32'(rdv[2]), 32'd0);
        tick();
        check("l4_load_rd_valid", 32'(rdv[2]), 32'd1);
        check("l4_load_old_data", rdd[2],      32'h1111_2222);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
